// File: rtl/mdu_seq_divider.sv
// rtl/mdu_seq_divider.sv - iterative radix-2 restoring divider with signed mode, remainder and abort
module mdu_seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             rfd,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH-1:0] dvnd_r;
    logic             neg_q;
    logic             neg_r;
    logic             dz_r;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_next;

    assign sgn   = SIGNED_EN && is_signed;
    assign a_neg = sgn && dividend[WIDTH-1];
    assign b_neg = sgn && divisor[WIDTH-1];
    // Two's-complement negation of MIN yields 2^(WIDTH-1), correct as an unsigned magnitude
    assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

    // Partial remainder stays below the divisor, so the difference always fits in WIDTH bits
    assign shifted  = {rem_r, quo_r[WIDTH-1]};
    assign ge       = shifted >= {1'b0, dvsr_r};
    assign rem_next = ge ? (shifted[WIDTH-1:0] - dvsr_r) : shifted[WIDTH-1:0];

    assign rfd  = (state == IDLE) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvsr_r      <= '0;
            dvnd_r      <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_r        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (start) begin
                        cnt    <= '0;
                        rem_r  <= '0;
                        quo_r  <= a_mag;
                        dvsr_r <= b_mag;
                        dvnd_r <= dividend;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz_r   <= (divisor == '0);
                        state  <= (divisor == '0) ? FIX : CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        rem_r <= rem_next;
                        quo_r <= {quo_r[WIDTH-2:0], ge};
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        if (dz_r) begin
                            quotient    <= '1;
                            remainder   <= dvnd_r;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= neg_q ? (~quo_r + 1'b1) : quo_r;
                            remainder   <= neg_r ? (~rem_r + 1'b1) : rem_r;
                            div_by_zero <= 1'b0;
                        end
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq_divider.sv
// tb/tb_mdu_seq_divider.sv - directed self-checking bench for mdu_seq_divider
module tb_mdu_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start1;
    logic        is_signed;
    logic        abort;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        rfd, done, dz;
    logic [31:0] quo, rem;
    logic        rfd1, done1, dz1;
    logic [31:0] quo1, rem1;

    int checks   = 0;
    int failures = 0;
    int lat;
    int rfd_low;

    always #5 clk = ~clk;

    mdu_seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .abort(abort),
        .dividend(dividend), .divisor(divisor), .rfd(rfd), .done(done),
        .quotient(quo), .remainder(rem), .div_by_zero(dz)
    );

    mdu_seq_divider #(.WIDTH(32), .SIGNED_EN(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_signed(is_signed), .abort(abort),
        .dividend(dividend), .divisor(divisor), .rfd(rfd1), .done(done1),
        .quotient(quo1), .remainder(rem1), .div_by_zero(dz1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for done; lat counts edges after the accept edge
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic both);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        start1    = both;
        step();
        start     = 1'b0;
        start1    = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0BAD_F00D;
        lat       = 0;
        rfd_low   = 0;
        while (!done && lat < 100) begin
            if (!rfd) rfd_low++;
            step();
            lat++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; is_signed = 1'b0; abort = 1'b0;
        dividend = '0; divisor = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_rfd", 32'(rfd), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_q", quo, 32'd0);
        chk("reset_r", rem, 32'd0);
        chk("reset_dz", 32'(dz), 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        chk("u100_7_lat", 32'(lat), 32'd33);
        chk("u100_7_rfdlow", 32'(rfd_low), 32'd33);
        chk("u100_7_q", quo, 32'd14);
        chk("u100_7_r", rem, 32'd2);
        chk("u100_7_dz", 32'(dz), 32'd0);
        step();
        chk("u100_7_done_once", 32'(done), 32'd0);
        chk("u100_7_rfd_after", 32'(rfd), 32'd1);

        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        chk("s_m7_2_q", quo, 32'hFFFF_FFFD);
        chk("s_m7_2_r", rem, 32'hFFFF_FFFF);
        chk("nosign_done", 32'(done1), 32'd1);
        chk("nosign_m7_2_q", quo1, 32'h7FFF_FFFC);
        chk("nosign_m7_2_r", rem1, 32'd1);

        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("u_m7_2_q", quo, 32'h7FFF_FFFC);
        chk("u_m7_2_r", rem, 32'd1);

        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        chk("s_7_m2_q", quo, 32'hFFFF_FFFD);
        chk("s_7_m2_r", rem, 32'd1);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("ovf_q", quo, 32'h8000_0000);
        chk("ovf_r", rem, 32'd0);
        chk("ovf_dz", 32'(dz), 32'd0);

        run_op(32'h1234_5678, 32'd0, 1'b1, 1'b0);
        chk("dz_s_lat", 32'(lat), 32'd1);
        chk("dz_s_q", quo, 32'hFFFF_FFFF);
        chk("dz_s_r", rem, 32'h1234_5678);
        chk("dz_s_dz", 32'(dz), 32'd1);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        chk("dz_u_lat", 32'(lat), 32'd1);
        chk("dz_u_q", quo, 32'hFFFF_FFFF);
        chk("dz_u_r", rem, 32'h1234_5678);
        chk("dz_u_dz", 32'(dz), 32'd1);

        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        step();
        // abort on the 10th CALC cycle: no done, previous result retained
        dividend = 32'h1234_5678; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_rfd", 32'(rfd), 32'd1);
        lat = 0;
        repeat (40) begin
            if (done) lat++;
            step();
        end
        chk("abort_no_done", 32'(lat), 32'd0);
        chk("abort_q", quo, 32'd14);
        chk("abort_r", rem, 32'd2);
        chk("abort_dz", 32'(dz), 32'd0);

        dividend = 32'd50; divisor = 32'd5; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_rfd", 32'(rfd), 32'd1);
        step();
        chk("abort_start_idle", 32'(rfd), 32'd1);
        chk("abort_start_q", quo, 32'd14);

        dividend = 32'hFFFF_0000; divisor = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_rfd", 32'(rfd), 32'd1);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_q", quo, 32'd0);
        chk("rst_mid_r", rem, 32'd0);
        chk("rst_mid_dz", 32'(dz), 32'd0);

        // back-to-back: start held through DONE, second op accepted in the DONE cycle
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        step();
        lat = 0;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        chk("b2b_first_lat", 32'(lat), 32'd33);
        chk("b2b_first_q", quo, 32'd14);
        chk("b2b_first_r", rem, 32'd2);
        dividend = 32'd1000; divisor = 32'd10;
        step();
        start = 1'b0;
        chk("b2b_no_gap_rfd", 32'(rfd), 32'd0);
        chk("b2b_no_gap_done", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        chk("b2b_second_lat", 32'(lat), 32'd33);
        chk("b2b_second_q", quo, 32'd100);
        chk("b2b_second_r", rem, 32'd0);
        step();
        chk("b2b_done_once", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
